// File: rtl/frame_receive_controller_pkg.sv
// Shared constants, FSM state encodings and the parity helper for the
// serial frame receiver.
package frame_receive_controller_pkg;

  localparam int FRAME_BITS_DEFAULT = 11;
  localparam int DATA_BITS          = 8;
  localparam int TIMEOUT_DEFAULT    = 50000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RECV  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;

  // Data plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/falling_edge_detect.sv
// Keeps the previous SYNC_CLK level and flags a high-to-low transition in
// the same cycle the low level is first seen.
module falling_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync_clk,
  output logic o_fall
);

  logic r_prev;

  // History register; resets high so a low line after reset reads as a fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_sync_clk;
    end
  end

  assign o_fall = r_prev & ~i_sync_clk;

endmodule

// File: rtl/frame_receive_controller.sv
// Receives start/8 data/odd parity/stop frames clocked by SYNC_CLK falling
// edges, validates them and hands the byte to a consumer with ACK handshake.
module frame_receive_controller
  import frame_receive_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int FRAME_BITS     = FRAME_BITS_DEFAULT
) (
  input  logic       FCLK,
  input  logic       RESET_N,
  input  logic       SYNC_CLK,
  input  logic       SYNC_DATA,
  input  logic       ACK,
  output logic [7:0] SCAN_CODE,
  output logic       CODE_VALID,
  output logic       PARITY_ERROR,
  output logic       FRAME_ERROR,
  output logic       OVERRUN,
  output logic [3:0] BIT_COUNT,
  output logic       BUSY
);

  localparam int                 TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]      TO_ONE    = TW'(1);
  localparam logic [TW-1:0]      TO_ZERO   = TW'(0);
  localparam logic [3:0]         BITS_MAX  = 4'(FRAME_BITS);
  localparam logic [FRAME_BITS-2:0] FRAME_ZERO = {(FRAME_BITS-1){1'b0}};

  state_t                  r_state;
  logic [3:0]              r_bit_count;
  logic [TW-1:0]           r_timeout;
  // Start bit is not stored: holds data LSB-first, then parity, then stop.
  logic [FRAME_BITS-2:0]   r_frame;
  logic [DATA_BITS-1:0]    r_scan_code;
  logic                    r_code_valid;
  logic                    r_parity_error;
  logic                    r_frame_error;
  logic                    r_overrun;

  logic                    w_fall;
  logic                    w_frame_done;
  logic                    w_timeout;
  logic                    w_check;
  logic                    w_stop_ok;
  logic                    w_parity_ok;
  logic                    w_accept;
  logic [DATA_BITS-1:0]    w_data;

  falling_edge_detect u_fall (
    .i_clk      (FCLK),
    .i_rst_n    (RESET_N),
    .i_sync_clk (SYNC_CLK),
    .o_fall     (w_fall)
  );

  assign w_frame_done = (r_bit_count == BITS_MAX);
  assign w_timeout    = (r_state == ST_RECV) & ~w_frame_done & ~w_fall & (r_timeout == TO_MAX);
  assign w_check      = (r_state == ST_CHECK);
  assign w_data       = r_frame[DATA_BITS-1:0];
  assign w_stop_ok    = r_frame[FRAME_BITS-2];
  assign w_parity_ok  = odd_parity_ok(r_frame[DATA_BITS:0]);
  assign w_accept     = w_check & w_stop_ok & w_parity_ok;

  // Frame sequencing: bit shifting, bit count and inter-edge timeout.
  always_ff @(posedge FCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_bit_count <= 4'd0;
      r_timeout   <= TO_ZERO;
      r_frame     <= FRAME_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timeout <= TO_ZERO;
          if (w_fall && !SYNC_DATA) begin
            r_state     <= ST_RECV;
            r_bit_count <= 4'd1;
          end
        end
        ST_RECV: begin
          if (w_frame_done) begin
            r_state   <= ST_CHECK;
            r_timeout <= TO_ZERO;
          end else if (w_fall) begin
            r_frame     <= {SYNC_DATA, r_frame[FRAME_BITS-2:1]};
            r_bit_count <= r_bit_count + 4'd1;
            r_timeout   <= TO_ZERO;
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_bit_count <= 4'd0;
            r_timeout   <= TO_ZERO;
          end else begin
            r_timeout <= r_timeout + TO_ONE;
          end
        end
        ST_CHECK: begin
          r_state     <= ST_IDLE;
          r_bit_count <= 4'd0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_bit_count <= 4'd0;
          r_timeout   <= TO_ZERO;
        end
      endcase
    end
  end

  // Consumer-facing byte register, handshake and error pulses.
  always_ff @(posedge FCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scan_code    <= 8'h00;
      r_code_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_parity_error <= w_check & w_stop_ok & ~w_parity_ok;
      r_frame_error  <= (w_check & ~w_stop_ok) | w_timeout;
      if (w_accept) begin
        if (r_code_valid && !ACK) begin
          r_overrun <= 1'b1;
        end else begin
          r_scan_code  <= w_data;
          r_code_valid <= 1'b1;
          r_overrun    <= 1'b0;
        end
      end else if (ACK && r_code_valid) begin
        r_code_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign SCAN_CODE    = r_scan_code;
  assign CODE_VALID   = r_code_valid;
  assign PARITY_ERROR = r_parity_error;
  assign FRAME_ERROR  = r_frame_error;
  assign OVERRUN      = r_overrun;
  assign BIT_COUNT    = r_bit_count;
  assign BUSY         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_frame_receive_controller.sv
// Directed bench for frame_receive_controller with a scoreboard of expected
// consumer-side state after each frame or acknowledge.
module tb_frame_receive_controller;

  logic       FCLK = 1'b0;
  logic       RESET_N;
  logic       SYNC_CLK;
  logic       SYNC_DATA;
  logic       ACK;
  logic [7:0] SCAN_CODE;
  logic       CODE_VALID;
  logic       PARITY_ERROR;
  logic       FRAME_ERROR;
  logic       OVERRUN;
  logic [3:0] BIT_COUNT;
  logic       BUSY;

  typedef struct {
    logic [7:0] code;
    logic       valid;
    logic       ovr;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_code;
  logic       m_valid;
  logic       m_ovr;

  frame_receive_controller #(.TIMEOUT_CYCLES(100), .FRAME_BITS(11)) dut (
    .FCLK         (FCLK),
    .RESET_N      (RESET_N),
    .SYNC_CLK     (SYNC_CLK),
    .SYNC_DATA    (SYNC_DATA),
    .ACK          (ACK),
    .SCAN_CODE    (SCAN_CODE),
    .CODE_VALID   (CODE_VALID),
    .PARITY_ERROR (PARITY_ERROR),
    .FRAME_ERROR  (FRAME_ERROR),
    .OVERRUN      (OVERRUN),
    .BIT_COUNT    (BIT_COUNT),
    .BUSY         (BUSY)
  );

  always #5 FCLK = ~FCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic push_state(input logic perr, input logic ferr);
    exp_t e;
    e.code  = m_code;
    e.valid = m_valid;
    e.ovr   = m_ovr;
    e.perr  = perr;
    e.ferr  = ferr;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed code %0h", tag, SCAN_CODE);
    end else begin
      e = sb.pop_front();
      chk({tag, ".code"},  32'(SCAN_CODE),    32'(e.code));
      chk({tag, ".valid"}, 32'(CODE_VALID),   32'(e.valid));
      chk({tag, ".ovr"},   32'(OVERRUN),      32'(e.ovr));
      chk({tag, ".perr"},  32'(PARITY_ERROR), 32'(e.perr));
      chk({tag, ".ferr"},  32'(FRAME_ERROR),  32'(e.ferr));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".code"},  32'(SCAN_CODE),    32'h00);
    chk({tag, ".valid"}, 32'(CODE_VALID),   32'd0);
    chk({tag, ".perr"},  32'(PARITY_ERROR), 32'd0);
    chk({tag, ".ferr"},  32'(FRAME_ERROR),  32'd0);
    chk({tag, ".ovr"},   32'(OVERRUN),      32'd0);
    chk({tag, ".count"}, 32'(BIT_COUNT),    32'd0);
    chk({tag, ".busy"},  32'(BUSY),         32'd0);
  endtask

  task automatic send_bit(input logic b);
    @(negedge FCLK);
    SYNC_DATA = b;
    SYNC_CLK  = 1'b1;
    repeat (3) @(negedge FCLK);
    SYNC_CLK = 1'b0;
    repeat (3) @(negedge FCLK);
  endtask

  task automatic send_frame(input string tag, input logic [10:0] f, input logic ack_in_check);
    logic perr;
    logic ferr;
    ferr = ~f[10];
    perr = f[10] & ~(^f[9:1]);
    if (!ferr && !perr) begin
      if (m_valid && !ack_in_check) begin
        m_ovr = 1'b1;
      end else begin
        m_code  = f[8:1];
        m_valid = 1'b1;
        m_ovr   = 1'b0;
      end
    end else if (ack_in_check && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    push_state(perr, ferr);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    @(negedge FCLK);
    SYNC_DATA = f[10];
    SYNC_CLK  = 1'b1;
    repeat (3) @(negedge FCLK);
    SYNC_CLK = 1'b0;
    repeat (2) @(negedge FCLK);
    chk({tag, ".check_busy"},  32'(BUSY),      32'd1);
    chk({tag, ".check_count"}, 32'(BIT_COUNT), 32'd11);
    ACK = ack_in_check;
    @(negedge FCLK);
    ACK = 1'b0;
    check_sb(tag);
    chk({tag, ".idle_busy"},  32'(BUSY),      32'd0);
    chk({tag, ".idle_count"}, 32'(BIT_COUNT), 32'd0);
    @(negedge FCLK);
    chk({tag, ".perr_end"}, 32'(PARITY_ERROR), 32'd0);
    chk({tag, ".ferr_end"}, 32'(FRAME_ERROR),  32'd0);
    SYNC_CLK = 1'b1;
  endtask

  task automatic do_ack(input string tag);
    @(negedge FCLK);
    ACK = 1'b1;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    push_state(1'b0, 1'b0);
    @(negedge FCLK);
    ACK = 1'b0;
    check_sb(tag);
  endtask

  initial begin
    int  cyc;
    logic got;
    RESET_N   = 1'b0;
    SYNC_CLK  = 1'b1;
    SYNC_DATA = 1'b1;
    ACK       = 1'b0;
    m_code    = 8'h00;
    m_valid   = 1'b0;
    m_ovr     = 1'b0;
    repeat (2) @(negedge FCLK);
    check_reset("reset");
    RESET_N = 1'b1;
    @(negedge FCLK);

    send_frame("good_1c", mk(8'h1C, 1'b0, 1'b1), 1'b0);
    do_ack("ack_1c");
    send_frame("parity_bad", mk(8'h1C, 1'b1, 1'b1), 1'b0);
    send_frame("stop_bad", mk(8'h1C, 1'b0, 1'b0), 1'b0);
    send_frame("both_bad", mk(8'h1C, 1'b1, 1'b0), 1'b0);

    send_bit(1'b1);
    chk("idle_high_busy",  32'(BUSY),      32'd0);
    chk("idle_high_count", 32'(BIT_COUNT), 32'd0);
    chk("idle_high_ferr",  32'(FRAME_ERROR), 32'd0);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("partial_count", 32'(BIT_COUNT), 32'd4);
    chk("partial_busy",  32'(BUSY),      32'd1);
    SYNC_CLK = 1'b1;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge FCLK);
      cyc = i + 1;
      if (FRAME_ERROR) got = 1'b1;
    end
    chk("timeout_ferr",   32'(got), 32'd1);
    chk("timeout_window", 32'((cyc >= 95) && (cyc <= 105)), 32'd1);
    chk("timeout_count",  32'(BIT_COUNT), 32'd0);
    chk("timeout_busy",   32'(BUSY),      32'd0);
    chk("timeout_valid",  32'(CODE_VALID), 32'(m_valid));
    send_frame("after_to_f0", mk(8'hF0, 1'b1, 1'b1), 1'b0);

    do_ack("ack_f0");
    send_frame("ovr_first_1c", mk(8'h1C, 1'b0, 1'b1), 1'b0);
    send_frame("ovr_second_f0", mk(8'hF0, 1'b1, 1'b1), 1'b0);
    do_ack("ack_ovr");
    do_ack("ack_idle");

    send_frame("pre_ack_1c", mk(8'h1C, 1'b0, 1'b1), 1'b0);
    send_frame("ack_same_f0", mk(8'hF0, 1'b1, 1'b1), 1'b1);

    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("mid_count", 32'(BIT_COUNT), 32'd5);
    @(negedge FCLK);
    RESET_N  = 1'b0;
    SYNC_CLK = 1'b1;
    m_code   = 8'h00;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge FCLK);
    RESET_N = 1'b1;
    send_frame("post_reset_1c", mk(8'h1C, 1'b0, 1'b1), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_receive_controller.md
FRAME_RECEIVE_CONTROLLER -- requirements
Module: frame_receive_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum FCLK cycles between SYNC_CLK falling edges inside a frame (1 ms at 50 MHz).
REQ-002 SHALL have parameter FRAME_BITS, default 11: start, 8 data, parity and stop.
REQ-003 SHALL have port FCLK  input  1  the single fast system clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SYNC_CLK  input  1  the already synchronized and debounced device clock.
REQ-006 SHALL have port SYNC_DATA  input  1  the already synchronized and debounced device data.
REQ-007 SHALL have port ACK  input  1  consumer acknowledge; it is a one-cycle pulse.
REQ-008 SHALL have port SCAN_CODE  output  8  the last accepted data byte.
REQ-009 SHALL have port CODE_VALID  output  1  high while SCAN_CODE holds an unacknowledged byte.
REQ-010 SHALL have port PARITY_ERROR  output  1  one-cycle pulse for an odd-parity failure.
REQ-011 SHALL have port FRAME_ERROR  output  1  one-cycle pulse for a bad stop bit or a timeout.
REQ-012 SHALL have port OVERRUN  output  1  sticky flag set when a frame is lost, cleared by ACK.
REQ-013 SHALL have port BIT_COUNT  output  4  the number of bits sampled in the current frame, 0..11.
REQ-014 SHALL have port BUSY  output  1  high outside the IDLE state.

Function
REQ-015 SHALL detect a SYNC_CLK falling edge when the registered previous SYNC_CLK is 1 and the current SYNC_CLK is 0; sampling of SYNC_DATA SHALL happen in that same cycle.
REQ-016 SHALL implement the states IDLE, RECV and CHECK.
REQ-017 In IDLE, a falling edge with SYNC_DATA=0 SHALL move the block to RECV with BIT_COUNT=1.
REQ-018 In IDLE, a falling edge with SYNC_DATA=1 SHALL be ignored: no flag, state unchanged.
REQ-019 In RECV, each falling edge SHALL shift SYNC_DATA into the frame register LSB-first and increment BIT_COUNT.
REQ-020 The RECV to CHECK transition SHALL occur on the cycle after the edge that brings BIT_COUNT to FRAME_BITS.
REQ-021 CHECK SHALL last exactly one cycle and then return to IDLE with BIT_COUNT=0.
REQ-022 CHECK SHALL accept the frame if data plus parity has an odd number of ones and stop=1.
REQ-023 On accept, SCAN_CODE SHALL load the byte and CODE_VALID SHALL rise on the FCLK edge that ends CHECK, i.e. 2 cycles after the stop-bit sampling edge.
REQ-024 If parity fails, PARITY_ERROR SHALL pulse and SCAN_CODE and CODE_VALID SHALL stay unchanged.
REQ-025 If stop=0, FRAME_ERROR SHALL pulse and SCAN_CODE and CODE_VALID SHALL stay unchanged; if both parity and stop fail, only FRAME_ERROR SHALL pulse.
REQ-026 The RECV timeout counter SHALL clear on every falling edge.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, FRAME_ERROR SHALL pulse and the block SHALL go to IDLE with BIT_COUNT=0, discarding the partial frame.
REQ-028 A frame accepted while CODE_VALID=1 and ACK=0 SHALL be discarded; OVERRUN SHALL set and SCAN_CODE SHALL keep the old byte.
REQ-029 ACK while CODE_VALID=1 SHALL clear CODE_VALID and OVERRUN on the next edge.
REQ-030 ACK while CODE_VALID=0 SHALL have no effect.
REQ-031 ACK in the same cycle as an accept SHALL load the new byte, keep CODE_VALID=1 and leave OVERRUN clear.
REQ-032 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and it SHALL saturate; BIT_COUNT SHALL never exceed FRAME_BITS.

Reset
REQ-033 RESET_N=0 SHALL immediately force: state=IDLE, SCAN_CODE=8'h00, CODE_VALID=0, PARITY_ERROR=0, FRAME_ERROR=0, OVERRUN=0, BIT_COUNT=0, BUSY=0, timeout counter=0 and the SYNC_CLK history register=1.
REQ-034 A reset asserted mid-frame SHALL discard the partial frame; the first falling edge after release SHALL be treated as occurring in IDLE.

Structure
REQ-035 A shared package SHALL hold the state enumeration, FRAME_BITS_DEFAULT=11, DATA_BITS=8 and TIMEOUT_DEFAULT=50000.
REQ-036 One sub-module, falling_edge_detect, SHALL provide the SYNC_CLK history register and the fall pulse.
REQ-037 The FSM, frame register, counters and output register SHALL reside in frame_receive_controller.

Verification
REQ-038 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) -> CODE_VALID=1 and SCAN_CODE=8'h1C 2 cycles after the stop edge; no error flags.
REQ-039 0x1C frame with parity=1 -> PARITY_ERROR pulses for one cycle; CODE_VALID stays 0.
REQ-040 0x1C frame with stop=0 -> FRAME_ERROR pulses once; BUSY returns to 0.
REQ-041 Four bits, then SYNC_CLK held high for TIMEOUT_CYCLES (parameter set to 100) -> FRAME_ERROR pulses and BIT_COUNT=0; a following 0xF0 frame (parity=1) -> SCAN_CODE=8'hF0.
REQ-042 Frames 0x1C then 0xF0 with no ACK -> SCAN_CODE stays 8'h1C and OVERRUN=1; then ACK -> CODE_VALID=0 and OVERRUN=0.
REQ-043 RESET_N pulsed low after 5 bits -> all outputs at reset values; a following 0x1C frame is received correctly.
